// File: rtl/add_sub_bist_if.sv
// Operand/result bus between the BIST engine and the combinational adder/subtracter.
// The BIST drives a/b (master); the unit under test returns sum/diff (slave).
interface add_sub_bist_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   modport master (output a, output b, input sum, input diff);
   modport slave  (input a, input b, output sum, output diff);
endinterface

// File: rtl/add_sub_bist.sv
// Exhaustive self-test of a WIDTH-bit adder/subtracter: sweeps all (a, b) pairs,
// holds each for SETTLE cycles, then checks sum/diff against wrap-around arithmetic.
module add_sub_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   add_sub_bist_if.master     uut,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]         state;
   logic [2*WIDTH-1:0] idx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   cur_a;
   logic [WIDTH-1:0]   cur_b;
   logic [WIDTH-1:0]   exp_sum;
   logic [WIDTH-1:0]   exp_diff;
   logic               mismatch;

   // Carry and borrow are dropped: results wrap modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return x + y;
   endfunction

   function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return x - y;
   endfunction

   assign cur_a    = idx[2*WIDTH-1:WIDTH];
   assign cur_b    = idx[WIDTH-1:0];
   assign uut.a    = cur_a;
   assign uut.b    = cur_b;
   assign exp_sum  = wrap_add(cur_a, cur_b);
   assign exp_diff = wrap_sub(cur_a, cur_b);
   assign mismatch = (uut.sum != exp_sum) || (uut.diff != exp_diff);

   assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
   assign done = (state == ST_DONE);
   assign pass = done && (err_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         cnt       <= '0;
         err_count <= '0;
         fail_a    <= '0;
         fail_b    <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  idx       <= '0;
                  cnt       <= CNT_RELOAD;
                  err_count <= '0;
                  fail_a    <= '0;
                  fail_b    <= '0;
                  state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == '0) state <= ST_CHECK;
               else           cnt   <= cnt - 1'b1;
            end
            ST_CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  // Only the first failing vector is recorded.
                  if (err_count == '0) begin
                     fail_a <= cur_a;
                     fail_b <= cur_b;
                  end
               end
               if (&idx) begin
                  state <= ST_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  cnt   <= CNT_RELOAD;
                  state <= ST_SETTLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_bist.sv
// Bench for add_sub_bist: models a (optionally faulty) 4-bit adder/subtracter and
// checks sweep timing, vector order and reported results against a reference.
module tb_add_sub_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   add_sub_bist_if #(.WIDTH(4)) bus1 ();
   add_sub_bist_if #(.WIDTH(4)) bus3 ();

   logic       busy1, done1, pass1, busy3, done3, pass3;
   logic [8:0] err1, err3;
   logic [3:0] fa1, fb1, fa3, fb3;

   add_sub_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .uut(bus1.master),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_a(fa1), .fail_b(fb1)
   );

   add_sub_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .uut(bus3.master),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .fail_a(fa3), .fail_b(fb3)
   );

   // Fault configuration of the modelled unit under test.
   bit stuck0;
   bit sum_flip [256];
   bit diff_flip [256];

   function automatic logic [3:0] model_sum(input logic [3:0] x, input logic [3:0] y);
      int s;
      s = (int'(x) + int'(y)) % 16;
      if (stuck0) s = s - (s % 2);
      if (sum_flip[{x, y}]) s = s ^ 8;
      return 4'(s);
   endfunction

   function automatic logic [3:0] model_diff(input logic [3:0] x, input logic [3:0] y);
      int d;
      d = (int'(x) - int'(y) + 16) % 16;
      if (diff_flip[{x, y}]) d = d ^ 1;
      return 4'(d);
   endfunction

   always @(negedge clk) begin
      bus1.sum  = model_sum(bus1.a, bus1.b);
      bus1.diff = model_diff(bus1.a, bus1.b);
      bus3.sum  = 4'((int'(bus3.a) + int'(bus3.b)) % 16);
      bus3.diff = 4'((int'(bus3.a) - int'(bus3.b) + 16) % 16);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      stuck0 = 1'b0;
      for (int i = 0; i < 256; i++) begin
         sum_flip[i]  = 1'b0;
         diff_flip[i] = 1'b0;
      end
   endtask

   // Reference: walk every pair in sweep order with plain arithmetic.
   task automatic ref_sweep(output int n, output int fa, output int fb);
      n = 0; fa = 0; fb = 0;
      for (int i = 0; i < 256; i++) begin
         int x, y;
         x = i / 16;
         y = i % 16;
         if (int'(model_sum(4'(x), 4'(y))) != (x + y) % 16 ||
             int'(model_diff(4'(x), 4'(y))) != (x - y + 16) % 16) begin
            if (n == 0) begin fa = x; fb = y; end
            n++;
         end
      end
   endtask

   function automatic logic get_busy(input bit sel);
      return sel ? busy3 : busy1;
   endfunction

   function automatic logic [7:0] get_ab(input bit sel);
      return sel ? {bus3.a, bus3.b} : {bus1.a, bus1.b};
   endfunction

   // Start a sweep; returns busy length, or returns early with rst_n dropped at reset_at.
   task automatic sweep(input bit sel, input int settle, input int start_at, input int reset_at,
                        output int cyc);
      @(negedge clk);
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      cyc = 0;
      while (get_busy(sel) && cyc < 4000) begin
         chk("ab_seq", 32'(get_ab(sel)), 32'((cyc / (settle + 1)) % 256));
         if (cyc == reset_at) begin
            #2 rst_n = 1'b0;
            return;
         end
         if (cyc == start_at) begin
            if (sel) start3 = 1'b1; else start1 = 1'b1;
         end
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         cyc++;
      end
   endtask

   task automatic check_results(input string tag, input int n, input int fa, input int fb);
      chk({tag, "_done"}, 32'(done1), 32'(1));
      chk({tag, "_busy"}, 32'(busy1), 32'(0));
      chk({tag, "_pass"}, 32'(pass1), 32'(n == 0));
      chk({tag, "_err"},  32'(err1), 32'(n));
      chk({tag, "_fa"},   32'(fa1), 32'(fa));
      chk({tag, "_fb"},   32'(fb1), 32'(fb));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ab"},   32'({bus1.a, bus1.b}), 32'(0));
      chk({tag, "_st"},   32'({busy1, done1, pass1}), 32'(0));
      chk({tag, "_err"},  32'(err1), 32'(0));
      chk({tag, "_fail"}, 32'({fa1, fb1}), 32'(0));
   endtask

   initial begin
      int cyc, n, fa, fb;
      clear_faults();

      // Asynchronous reset between edges, then idle with start low.
      #3 rst_n = 1'b0;
      #1 check_zero("rst");
      chk("rst3", 32'({busy3, done3, pass3, err3}), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle", 32'({busy1, done1, pass1, err1, fa1, fb1, bus1.a, bus1.b}), 32'(0));
      end

      // Golden unit.
      sweep(1'b0, 1, -1, -1, cyc);
      chk("gold_len", 32'(cyc), 32'(512));
      check_results("gold", 0, 0, 0);

      // sum[0] stuck at 0: every odd a+b fails.
      stuck0 = 1'b1;
      sweep(1'b0, 1, -1, -1, cyc);
      chk("stuck_len", 32'(cyc), 32'(512));
      check_results("stuck", 128, 0, 1);
      ref_sweep(n, fa, fb);
      check_results("stuck_ref", n, fa, fb);

      // Single diff fault at a=F, b=1.
      clear_faults();
      diff_flip[8'hF1] = 1'b1;
      sweep(1'b0, 1, -1, -1, cyc);
      check_results("diff1", 1, 15, 1);

      // A vector with both outputs wrong still counts once.
      sum_flip[8'h35]  = 1'b1;
      diff_flip[8'h35] = 1'b1;
      sweep(1'b0, 1, -1, -1, cyc);
      check_results("both", 2, 3, 5);

      // Restart from DONE after a failing run, with a stray start mid-sweep.
      clear_faults();
      sweep(1'b0, 1, 50, -1, cyc);
      chk("midstart_len", 32'(cyc), 32'(512));
      check_results("rerun", 0, 0, 0);
      repeat (3) @(negedge clk);
      check_results("held", 0, 0, 0);

      // Randomized fault patterns against the reference.
      for (int r = 0; r < 4; r++) begin
         clear_faults();
         stuck0 = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 256; i++) begin
            sum_flip[i]  = ($urandom_range(0, 15) == 0);
            diff_flip[i] = ($urandom_range(0, 15) == 0);
         end
         repeat ($urandom_range(0, 5)) @(negedge clk);
         ref_sweep(n, fa, fb);
         sweep(1'b0, 1, -1, -1, cyc);
         chk("rand_len", 32'(cyc), 32'(512));
         check_results("rand", n, fa, fb);
      end

      // Reset in the middle of a sweep aborts it.
      clear_faults();
      stuck0 = 1'b1;
      sweep(1'b0, 1, -1, 100, cyc);
      #1 check_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_rst", 32'({busy1, done1, err1, bus1.a, bus1.b}), 32'(0));
      end

      // SETTLE=3 instance.
      sweep(1'b1, 3, -1, -1, cyc);
      chk("s3_len", 32'(cyc), 32'(1024));
      chk("s3_done", 32'(done3), 32'(1));
      chk("s3_pass", 32'(pass3), 32'(1));
      chk("s3_err", 32'(err3), 32'(0));
      chk("s3_fail", 32'({fa3, fb3}), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_sub_bist.md
Name: add_sub_bist

Overview:
- Built-in self-test driver/checker for the combinational 4-bit adder/subtracter.
- Acts as the stimulus and response end of that unit's a/b -> sum/diff interface, in hardware.
- On start it sweeps every (a, b) operand pair, waits a settle time, and compares sum/diff against internally computed expected values.
- Reports pass/fail, error count and the first failing vector. Sits beside the adder/subtracter in the board-level test wrapper.

Parameters:
- WIDTH, 4: operand width of the unit under test.
- SETTLE, 1: cycles (>=1) operands are held before results are sampled.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sweep
- a  output  WIDTH  operand A driven to unit under test (registered)
- b  output  WIDTH  operand B driven to unit under test (registered)
- sum  input  WIDTH  sum returned by unit under test
- diff  input  WIDTH  difference returned by unit under test
- busy  output  1  sweep in progress
- done  output  1  sweep complete; level, held until next start or reset
- pass  output  1  valid while done=1: 1 when err_count==0
- err_count  output  2*WIDTH+1  number of failing vectors
- fail_a  output  WIDTH  A of first failing vector (0 if none)
- fail_b  output  WIDTH  B of first failing vector (0 if none)

Behaviour:
- Reset is one clock and asynchronous active-low. While rst_n=0, all outputs are 0 and the state is IDLE, taking effect immediately without a clock edge. Reset mid-sweep aborts the sweep; there is no resume.
- Vector index idx is 2*WIDTH bits. a = idx[2W-1:W], b = idx[W-1:0]. Order: a=0,b=0; a=0,b=1; ... a=max,b=max.
- Expected values: exp_sum = (a+b) mod 2^W; exp_diff = (a-b) mod 2^W (two's-complement wrap). Carry and borrow are discarded.
- States:
  - IDLE: busy=0, done=0. On start=1: idx<=0, a,b<=0, err_count<=0, fail_a/fail_b<=0, settle counter<=SETTLE-1, go to SETTLE.
  - SETTLE: busy=1. Stays exactly SETTLE cycles (counter decrements; leave when it is 0), then go to CHECK.
  - CHECK: busy=1, one cycle. Sample sum/diff. Mismatch if sum!=exp_sum or diff!=exp_diff; a vector counts once even if both mismatch. On mismatch: err_count++; if err_count was 0, capture fail_a<=a, fail_b<=b.
    - If idx is all-ones: go to DONE.
    - Else: idx++, a/b update in the same edge, counter reload, go to SETTLE.
  - DONE: busy=0, done=1, pass=(err_count==0). Results are held. start=1 begins a new sweep exactly as from IDLE, clearing results.
- start is ignored while busy=1.
- Latency: the start edge is cycle 0. busy is high for 2^(2W)*(SETTLE+1) cycles, then done rises. For defaults: 256*2 = 512 cycles.
- err_count cannot overflow (max 2^(2W) fits in 2W+1 bits).
- pass and fail_a/fail_b are meaningful only while done=1; they read 0 in IDLE.

Test Plan:
1. Reset: assert rst_n=0 asynchronously between edges -> a=b=0, busy=done=pass=0, err_count=0 immediately. Hold idle 10 cycles with start=0 -> no change.
2. Golden DUT (exact add/sub model), start pulse -> busy=1 for exactly 512 cycles, a/b step through all 256 pairs, then done=1, pass=1, err_count=0, fail_a=fail_b=0.
3. Faulty DUT with sum[0] stuck at 0 -> err_count=128, pass=0, fail_a=0, fail_b=1.
4. Faulty DUT whose diff is wrong only for a=4'b1111, b=4'b0001 -> err_count=1, fail_a=4'hF, fail_b=4'h1. Also check a vector with both sum and diff wrong counts once.
5. Pulse start at cycle 50 of a run -> ignored, done still at cycle 512. Then start from DONE with golden DUT after a failing run -> err_count cleared, pass=1 after 512 cycles.
6. Drop rst_n at cycle 100 of a sweep -> outputs zero at once, done never rises. After release the block stays IDLE until start. Rerun with SETTLE=3 -> busy lasts 1024 cycles.
